ltssm_ts_rx_checker: RTL and testbench
======================================

Name: ltssm_ts_rx_checker

Overview:
- Receive-side counterpart of the polling TS transmitter.
- Consumes the AXI-Stream of ordered sets coming up from the per-lane descrambler/deskew path.
- Assembles 16-symbol TS1/TS2 ordered sets and checks their format.
- Counts consecutive identical sets per lane and drives per-lane lanes_ts1_satisfied / lanes_ts2_satisfied to the LTSSM substates (Polling, Configuration).

Parameters:
- MAX_NUM_LANES, 4, number of lanes tracked; lane index width LW = $clog2(MAX_NUM_LANES), min 1.
- DATA_WIDTH, 32, stream data width; fixed at 32 (4 symbols per beat).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 8, tuser width. tuser[0] = ordered-set flag; tuser[1+:LW] = lane index.
- TS_COUNT_TARGET, 8, consecutive identical sets needed for satisfied.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- en_i  in  1  checker enable
- clear_i  in  1  synchronous clear of all counters and satisfied flags
- s_axis_tdata_i  in  DATA_WIDTH  symbols; byte0 = lowest symbol of beat
- s_axis_tkeep_i  in  KEEP_WIDTH  must be all-ones on OS beats
- s_axis_tvalid_i  in  1  beat valid
- s_axis_tlast_i  in  1  last beat of ordered set
- s_axis_tuser_i  in  USER_WIDTH  see parameters
- s_axis_tready_o  out  1  sink ready
- lanes_ts1_satisfied_o  out  MAX_NUM_LANES  sticky per-lane TS1 condition met
- lanes_ts2_satisfied_o  out  MAX_NUM_LANES  sticky per-lane TS2 condition met
- ts_valid_o  out  1  one-cycle pulse: well-formed set accepted
- ts_type_o  out  1  0 = TS1, 1 = TS2; valid with ts_valid_o
- ts_lane_o  out  LW  lane of accepted set
- ts_link_num_o  out  8  symbol 1 of accepted set
- ts_lane_num_o  out  8  symbol 2 of accepted set
- malformed_o  out  1  one-cycle pulse: set discarded as malformed

Behaviour:
- Reset values: all outputs 0, including s_axis_tready_o. Assembly beat count 0; all lane counters 0.
- Handshake: s_axis_tready_o is registered; it goes to 1 on the first clk_i edge after rst_i deasserts and stays 1. A beat is accepted when tvalid && tready. No backpressure.
- Assembly:
  - 2-bit beat counter; beat k carries symbols 4k..4k+3. Lane is captured on beat 0.
  - A set completes on the beat-3 accept with tlast = 1.
  - tlast before beat 3, or no tlast on beat 3: abort, pulse malformed_o, counter back to 0.
- Non-OS beats (tuser[0] = 0): ignored. A partial set in progress is silently discarded; no counter change.
- Validation, evaluated at completion:
  - sym0 == 8'hBC;
  - symbols 6..15 all 8'h4A (TS1) or all 8'h45 (TS2);
  - tkeep all-ones on every beat;
  - lane < MAX_NUM_LANES.
  - Any failure: malformed_o pulse. If the lane is in range, that lane's TS1/TS2 counters are zeroed.
- Per lane, state kept: 40-bit prev field (symbols 1..5), prev type, ts1_cnt, ts2_cnt. Counters are saturating, width $clog2(TS_COUNT_TARGET+1).
- Valid set, same type as prev and symbols 1..5 equal prev: that type's counter += 1 (saturate).
- Valid set, otherwise: that type's counter = 1, the other type's counter = 0; prev is updated.
- Satisfied flags:
  - lanes_ts1_satisfied[l] is set when ts1_cnt reaches TS_COUNT_TARGET; same for TS2.
  - Both are sticky until clear_i or reset; a later mismatch does not drop them.
- Latency:
  - ts_valid_o, the decoded fields and malformed_o assert the cycle after the completing beat is accepted.
  - Satisfied asserts in that same cycle, i.e. 1 cycle after the TARGET-th completing tlast beat.
- en_i = 0: beats are still accepted (tready = 1), assembly is held at beat 0, no counter/flag updates, no pulses. Flags keep their value.
- en_i falling mid-set: the partial set is discarded.
- clear_i = 1: all counters, prev fields and flags are zeroed next cycle; assembly is aborted. If clear_i coincides with a completing beat, clear wins: the set is discarded and no pulse is produced.
- rst_i mid-set: immediate return to reset values; the partial set is lost.
- No state is shared between lanes. Sets from different lanes may interleave only at set boundaries.

Test Plan:
- 8 back-to-back TS1 on lane 0 (link 8'hF7, lane 8'hF7, N_FTS 8'h10): ts_valid_o pulses 8 times; lanes_ts1_satisfied_o = 4'b0001 exactly 1 cycle after the 8th tlast; lanes_ts2_satisfied_o = 0.
- 4 TS2 on lane 1 (N_FTS 8'h10), then 1 TS2 with N_FTS 8'h20, then 7 more with 8'h20: satisfied[1] sets only after the 8th set with 8'h20; never before.
- TS1 on lane 2 with sym0 = 8'h1C, then sym10 = 8'h45 in a TS1: malformed_o pulses twice; lane-2 count returns to 0; a further 8 good TS1 are needed.
- tuser lane = 3 with MAX_NUM_LANES = 3, and tlast on beat 1: malformed_o pulses; no flags change; the following good set is assembled correctly.
- Lane 0 already TS1-satisfied; clear_i asserted on the completing beat of another TS1: flags go to 0, no ts_valid_o pulse; 8 fresh sets are needed to re-satisfy.
- rst_i asserted after beat 1 of a set, released, and a full TS1 sent: tready low during reset; the stale partial set is not merged; ts_valid_o pulses once with ts_type_o = 0.

Source files
------------

// File: rtl/ltssm_ts_rx_checker.sv
// ----------------------------------------------------------------------------
// ltssm_ts_rx_checker
//
// Receive-side TS1/TS2 checker for the LTSSM. Assembles 16-symbol ordered sets
// from a 32-bit AXI-Stream (four beats per set) and validates their format.
// It also counts consecutive identical sets per lane and raises sticky
// per-lane "satisfied" flags once TS_COUNT_TARGET identical sets have been
// seen in a row.
//
// Ports
//   clk_i, rst_i            clock; asynchronous active-high reset
//   en_i                    checker enable (beats are still accepted when low)
//   clear_i                 synchronous clear of counters, prev fields, flags
//   s_axis_*_i              ordered-set stream; tuser[0] = OS flag,
//                           tuser[1+:LW] = lane index
//   s_axis_tready_o         always ready once out of reset
//   lanes_ts1_satisfied_o   sticky per-lane TS1 condition met
//   lanes_ts2_satisfied_o   sticky per-lane TS2 condition met
//   ts_valid_o              one-cycle pulse: well-formed set accepted
//   ts_type_o/lane_o/...    decoded fields, valid with ts_valid_o
//   malformed_o             one-cycle pulse: set discarded as malformed
// ----------------------------------------------------------------------------
module ltssm_ts_rx_checker #(
    parameter int MAX_NUM_LANES   = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int USER_WIDTH      = 8,
    parameter int TS_COUNT_TARGET = 8,
    localparam int LW = (MAX_NUM_LANES > 1) ? $clog2(MAX_NUM_LANES) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata_i,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep_i,
    input  logic                     s_axis_tvalid_i,
    input  logic                     s_axis_tlast_i,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser_i,
    output logic                     s_axis_tready_o,
    output logic [MAX_NUM_LANES-1:0] lanes_ts1_satisfied_o,
    output logic [MAX_NUM_LANES-1:0] lanes_ts2_satisfied_o,
    output logic                     ts_valid_o,
    output logic                     ts_type_o,
    output logic [LW-1:0]            ts_lane_o,
    output logic [7:0]               ts_link_num_o,
    output logic [7:0]               ts_lane_num_o,
    output logic                     malformed_o
);
    localparam int CW = $clog2(TS_COUNT_TARGET + 1);
    localparam logic [CW-1:0] TARGET   = CW'(TS_COUNT_TARGET);
    localparam logic [LW:0]   NUM_LANE = (LW + 1)'(MAX_NUM_LANES);

    // Assembly state
    logic          r_tready;
    logic [1:0]    r_beat;
    logic [LW-1:0] r_lane;
    logic [95:0]   r_sym;      // symbols 0..11 (beats 0..2), symbol 0 in [7:0]
    logic          r_keep_ok;

    // Per-lane tracking state
    logic [39:0]   r_prev      [MAX_NUM_LANES];
    logic          r_prev_type [MAX_NUM_LANES];
    logic [CW-1:0] r_ts1_cnt   [MAX_NUM_LANES];
    logic [CW-1:0] r_ts2_cnt   [MAX_NUM_LANES];
    logic [MAX_NUM_LANES-1:0] r_sat1, r_sat2;

    // Output pulse/field registers
    logic          r_ts_valid, r_ts_type, r_malformed;
    logic [LW-1:0] r_ts_lane;
    logic [7:0]    r_link_num, r_lane_num;

    logic          w_os_acc, w_keep_full, w_all_4a, w_all_45, w_fmt_ok, w_lane_ok;
    logic          w_end, w_abort, w_good, w_bad, w_is_ts2;
    logic [127:0]  w_syms;
    logic [39:0]   w_sym15;
    logic [CW-1:0] w_ts1_nxt [MAX_NUM_LANES];
    logic [CW-1:0] w_ts2_nxt [MAX_NUM_LANES];
    logic [MAX_NUM_LANES-1:0] w_upd;
    logic          w_unused_tuser;

    assign w_unused_tuser = ^s_axis_tuser_i[USER_WIDTH-1:LW+1];

    assign w_os_acc    = s_axis_tvalid_i && r_tready && s_axis_tuser_i[0];
    assign w_keep_full = &s_axis_tkeep_i;
    assign w_syms      = {s_axis_tdata_i, r_sym};
    assign w_sym15     = w_syms[47:8];
    assign w_lane_ok   = {1'b0, r_lane} < NUM_LANE;

    // Clear and disable suppress every completion/abort event.
    assign w_end   = w_os_acc && en_i && !clear_i && (r_beat == 2'd3) && s_axis_tlast_i;
    assign w_abort = w_os_acc && en_i && !clear_i &&
                     ((r_beat != 2'd3) == s_axis_tlast_i);

    // NOTE: every signal driven from always_comb gets a default at the top so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_all_4a = 1'b1;
        w_all_45 = 1'b1;
        for (int i = 6; i < 16; i++) begin
            w_all_4a &= (w_syms[8*i +: 8] == 8'h4A);
            w_all_45 &= (w_syms[8*i +: 8] == 8'h45);
        end
        w_fmt_ok = (w_syms[7:0] == 8'hBC) && (w_all_4a || w_all_45) &&
                   r_keep_ok && w_keep_full && w_lane_ok;
        w_is_ts2 = !w_all_4a;
        w_good   = w_end && w_fmt_ok;
        w_bad    = w_end && !w_fmt_ok;
    end

    // Next counter values per lane; only the addressed lane is updated.
    always_comb begin
        for (int l = 0; l < MAX_NUM_LANES; l++) begin
            w_ts1_nxt[l] = r_ts1_cnt[l];
            w_ts2_nxt[l] = r_ts2_cnt[l];
            w_upd[l]     = 1'b0;
            if (r_lane == LW'(l)) begin
                if (w_bad && w_lane_ok) begin
                    w_upd[l]     = 1'b1;
                    w_ts1_nxt[l] = '0;
                    w_ts2_nxt[l] = '0;
                end else if (w_good) begin
                    w_upd[l] = 1'b1;
                    if (r_prev_type[l] == w_is_ts2 && r_prev[l] == w_sym15) begin
                        if (w_is_ts2)
                            w_ts2_nxt[l] = (r_ts2_cnt[l] == TARGET) ? TARGET : r_ts2_cnt[l] + CW'(1);
                        else
                            w_ts1_nxt[l] = (r_ts1_cnt[l] == TARGET) ? TARGET : r_ts1_cnt[l] + CW'(1);
                    end else begin
                        w_ts1_nxt[l] = w_is_ts2 ? '0 : CW'(1);
                        w_ts2_nxt[l] = w_is_ts2 ? CW'(1) : '0;
                    end
                end
            end
        end
    end

    // Beat assembly
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tready  <= 1'b0;
            r_beat    <= 2'd0;
            r_lane    <= '0;
            r_sym     <= '0;
            r_keep_ok <= 1'b0;
        end else begin
            r_tready <= 1'b1;
            if (clear_i || !en_i) begin
                r_beat <= 2'd0;
            end else if (s_axis_tvalid_i && r_tready) begin
                if (!s_axis_tuser_i[0] || s_axis_tlast_i || r_beat == 2'd3) begin
                    r_beat <= 2'd0;     // non-OS beat, completion or abort
                end else begin
                    r_beat    <= r_beat + 2'd1;
                    r_keep_ok <= (r_beat == 2'd0) ? w_keep_full : (r_keep_ok && w_keep_full);
                    case (r_beat)
                        2'd0: begin
                            r_sym[31:0] <= s_axis_tdata_i;
                            r_lane      <= s_axis_tuser_i[1 +: LW];
                        end
                        2'd1:    r_sym[63:32] <= s_axis_tdata_i;
                        default: r_sym[95:64] <= s_axis_tdata_i;
                    endcase
                end
            end
        end
    end

    // Per-lane counters, prev fields and sticky flags
    // NOTE: the per-lane arrays are few and small, so they are reset with the
    // rest of the state; a prev-field compare never sees undefined values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sat1 <= '0;
            r_sat2 <= '0;
            for (int l = 0; l < MAX_NUM_LANES; l++) begin
                r_prev[l]      <= '0;
                r_prev_type[l] <= 1'b0;
                r_ts1_cnt[l]   <= '0;
                r_ts2_cnt[l]   <= '0;
            end
        end else if (clear_i) begin
            r_sat1 <= '0;
            r_sat2 <= '0;
            for (int l = 0; l < MAX_NUM_LANES; l++) begin
                r_prev[l]      <= '0;
                r_prev_type[l] <= 1'b0;
                r_ts1_cnt[l]   <= '0;
                r_ts2_cnt[l]   <= '0;
            end
        end else begin
            for (int l = 0; l < MAX_NUM_LANES; l++) begin
                if (w_upd[l]) begin
                    r_ts1_cnt[l] <= w_ts1_nxt[l];
                    r_ts2_cnt[l] <= w_ts2_nxt[l];
                    r_sat1[l]    <= r_sat1[l] || (w_ts1_nxt[l] == TARGET);
                    r_sat2[l]    <= r_sat2[l] || (w_ts2_nxt[l] == TARGET);
                    if (w_good) begin
                        r_prev[l]      <= w_sym15;
                        r_prev_type[l] <= w_is_ts2;
                    end
                end
            end
        end
    end

    // Result pulses and decoded fields (fields hold between pulses)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ts_valid  <= 1'b0;
            r_malformed <= 1'b0;
            r_ts_type   <= 1'b0;
            r_ts_lane   <= '0;
            r_link_num  <= '0;
            r_lane_num  <= '0;
        end else begin
            r_ts_valid  <= w_good;
            r_malformed <= w_bad || w_abort;
            if (w_good) begin
                r_ts_type  <= w_is_ts2;
                r_ts_lane  <= r_lane;
                r_link_num <= w_syms[15:8];
                r_lane_num <= w_syms[23:16];
            end
        end
    end

    assign s_axis_tready_o       = r_tready;
    assign lanes_ts1_satisfied_o = r_sat1;
    assign lanes_ts2_satisfied_o = r_sat2;
    assign ts_valid_o            = r_ts_valid;
    assign ts_type_o             = r_ts_type;
    assign ts_lane_o             = r_ts_lane;
    assign ts_link_num_o         = r_link_num;
    assign ts_lane_num_o         = r_lane_num;
    assign malformed_o           = r_malformed;

endmodule

// File: tb/tb_ltssm_ts_rx_checker.sv
// ----------------------------------------------------------------------------
// tb_ltssm_ts_rx_checker
//
// Self-checking bench for ltssm_ts_rx_checker, built with three lanes so that
// lane index 3 is out of range. A reference model tracks, per lane, the last
// accepted set and the length of the current run of identical sets; satisfied
// flags follow from "a run of TARGET identical TS1 (TS2) sets has occurred".
// ----------------------------------------------------------------------------
module tb_ltssm_ts_rx_checker;
    localparam int NL  = 3;
    localparam int LW  = 2;
    localparam int TGT = 8;

    logic          clk_i = 1'b0;
    logic          rst_i, en_i, clear_i;
    logic [31:0]   tdata;
    logic [3:0]    tkeep;
    logic          tvalid, tlast;
    logic [7:0]    tuser;
    logic          tready;
    logic [NL-1:0] sat1, sat2;
    logic          ts_valid, ts_type, malformed;
    logic [LW-1:0] ts_lane;
    logic [7:0]    link_num, lane_num;

    always #5 clk_i = ~clk_i;

    ltssm_ts_rx_checker #(
        .MAX_NUM_LANES  (NL),
        .TS_COUNT_TARGET(TGT)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .en_i                 (en_i),
        .clear_i              (clear_i),
        .s_axis_tdata_i       (tdata),
        .s_axis_tkeep_i       (tkeep),
        .s_axis_tvalid_i      (tvalid),
        .s_axis_tlast_i       (tlast),
        .s_axis_tuser_i       (tuser),
        .s_axis_tready_o      (tready),
        .lanes_ts1_satisfied_o(sat1),
        .lanes_ts2_satisfied_o(sat2),
        .ts_valid_o           (ts_valid),
        .ts_type_o            (ts_type),
        .ts_lane_o            (ts_lane),
        .ts_link_num_o        (link_num),
        .ts_lane_num_o        (lane_num),
        .malformed_o          (malformed)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [40:0]   m_last [NL];
    bit            m_have [NL];
    int            m_run  [NL];
    logic [NL-1:0] m_sat1, m_sat2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int l = 0; l < NL; l++) begin
            m_have[l] = 1'b0;
            m_run[l]  = 0;
        end
        m_sat1 = '0;
        m_sat2 = '0;
    endtask

    // Symbols 1..5: link, lane, N_FTS, rate, training control
    function automatic logic [39:0] fld(input logic [7:0] link, input logic [7:0] lnum,
                                        input logic [7:0] nfts);
        return {8'h00, 8'h02, nfts, lnum, link};
    endfunction

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                              input logic [7:0] u);
        @(negedge clk_i);
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tuser  = u;
    endtask

    task automatic idle();
        @(negedge clk_i);
        tvalid  = 1'b0;
        tlast   = 1'b0;
        clear_i = 1'b0;
    endtask

    // bad: 0 good, 1 sym0 wrong, 2 sym10 wrong, 3 short tkeep on beat 2,
    //      4 tlast on beat 1, 5 no tlast on beat 3
    task automatic send_set(input int lane, input bit ts2, input logic [39:0] f,
                            input int bad, input bit clr);
        logic [7:0]  sym [16];
        logic [7:0]  u;
        logic [40:0] key;
        int          nb;
        bit          exp_v, exp_m;
        sym[0] = 8'hBC;
        for (int i = 1; i <= 5; i++) sym[i] = f[8*(i-1) +: 8];
        for (int i = 6; i < 16; i++) sym[i] = ts2 ? 8'h45 : 8'h4A;
        if (bad == 1) sym[0] = 8'h1C;
        if (bad == 2) sym[10] = ts2 ? 8'h4A : 8'h45;
        u  = {5'b0, 2'(lane), 1'b1};
        nb = (bad == 4) ? 2 : 4;
        for (int k = 0; k < nb; k++) begin
            drive_beat({sym[4*k+3], sym[4*k+2], sym[4*k+1], sym[4*k]},
                       (bad == 3 && k == 2) ? 4'b0111 : 4'b1111,
                       (bad == 4) ? (k == 1) : (k == 3 && bad != 5), u);
            clear_i = clr && (k == nb - 1);
        end
        idle();

        exp_v = 1'b0;
        exp_m = 1'b0;
        if (clr) begin
            model_clear();
        end else if (!en_i) begin
            exp_v = 1'b0;
        end else if (bad == 4 || bad == 5) begin
            exp_m = 1'b1;
        end else if (bad != 0 || lane >= NL) begin
            exp_m = 1'b1;
            if (lane < NL) m_run[lane] = 0;
        end else begin
            exp_v = 1'b1;
            key   = {ts2, f};
            if (m_have[lane] && m_last[lane] == key) m_run[lane]++;
            else m_run[lane] = 1;
            m_last[lane] = key;
            m_have[lane] = 1'b1;
            if (m_run[lane] >= TGT) begin
                if (ts2) m_sat2[lane] = 1'b1;
                else     m_sat1[lane] = 1'b1;
            end
        end

        check("ts_valid", 64'(ts_valid), 64'(exp_v));
        check("malformed", 64'(malformed), 64'(exp_m));
        if (exp_v) begin
            check("ts_type", 64'(ts_type), 64'(ts2));
            check("ts_lane", 64'(ts_lane), 64'(lane));
            check("link_num", 64'(link_num), 64'(f[7:0]));
            check("lane_num", 64'(lane_num), 64'(f[15:8]));
        end
        check("ts1_satisfied", 64'(sat1), 64'(m_sat1));
        check("ts2_satisfied", 64'(sat2), 64'(m_sat2));
        @(negedge clk_i);
        check("pulse_end", 64'({ts_valid, malformed}), 64'(0));
    endtask

    initial begin
        int  lane;
        bit  ts2;
        int  bad;
        logic [39:0] f;

        rst_i   = 1'b1;
        en_i    = 1'b1;
        clear_i = 1'b0;
        tvalid  = 1'b0;
        tdata   = '0;
        tkeep   = '0;
        tlast   = 1'b0;
        tuser   = '0;
        model_clear();
        repeat (3) @(negedge clk_i);
        check("reset_tready", 64'(tready), 64'(0));
        check("reset_flags", 64'({sat1, sat2}), 64'(0));
        check("reset_pulses", 64'({ts_valid, malformed}), 64'(0));
        rst_i = 1'b0;
        @(negedge clk_i);
        check("tready_up", 64'(tready), 64'(1));

        // Eight identical TS1 on lane 0
        repeat (TGT) send_set(0, 1'b0, fld(8'hF7, 8'hF7, 8'h10), 0, 1'b0);

        // TS2 on lane 1: run broken by an N_FTS change, then eight with 8'h20
        repeat (4) send_set(1, 1'b1, fld(8'h01, 8'h01, 8'h10), 0, 1'b0);
        repeat (TGT) send_set(1, 1'b1, fld(8'h01, 8'h01, 8'h20), 0, 1'b0);

        // Lane 2: partial run, two malformed sets, then a full fresh run
        repeat (5) send_set(2, 1'b0, fld(8'h02, 8'h02, 8'h10), 0, 1'b0);
        send_set(2, 1'b0, fld(8'h02, 8'h02, 8'h10), 1, 1'b0);
        send_set(2, 1'b0, fld(8'h02, 8'h02, 8'h10), 2, 1'b0);
        repeat (TGT) send_set(2, 1'b0, fld(8'h02, 8'h02, 8'h10), 0, 1'b0);

        // Out-of-range lane, early tlast, bad tkeep, missing tlast, then a good set
        send_set(3, 1'b0, fld(8'h03, 8'h03, 8'h10), 0, 1'b0);
        send_set(0, 1'b0, fld(8'hF7, 8'hF7, 8'h10), 4, 1'b0);
        send_set(1, 1'b1, fld(8'h01, 8'h01, 8'h20), 3, 1'b0);
        send_set(1, 1'b1, fld(8'h01, 8'h01, 8'h20), 5, 1'b0);
        send_set(2, 1'b0, fld(8'h22, 8'h05, 8'h10), 0, 1'b0);

        // Non-OS beat discards a partial set silently
        drive_beat(32'h01_01_01_BC, 4'hF, 1'b0, 8'h03);
        drive_beat(32'h4A_4A_00_02, 4'hF, 1'b0, 8'h03);
        drive_beat(32'h4A_4A_4A_4A, 4'hF, 1'b1, 8'h00);
        idle();
        check("non_os_no_malformed", 64'(malformed), 64'(0));
        send_set(1, 1'b0, fld(8'h44, 8'h01, 8'h10), 0, 1'b0);

        // Disabled: beats accepted, nothing reported
        en_i = 1'b0;
        send_set(0, 1'b1, fld(8'h55, 8'h00, 8'h10), 0, 1'b0);
        check("disabled_tready", 64'(tready), 64'(1));
        en_i = 1'b1;

        // en_i falling mid-set drops the partial set
        drive_beat(32'h10_F7_F7_BC, 4'hF, 1'b0, 8'h01);
        drive_beat(32'h4A_4A_00_02, 4'hF, 1'b0, 8'h01);
        idle();
        en_i = 1'b0;
        @(negedge clk_i);
        en_i = 1'b1;
        check("en_drop_no_pulse", 64'({ts_valid, malformed}), 64'(0));
        send_set(0, 1'b0, fld(8'hF7, 8'hF7, 8'h10), 0, 1'b0);

        // Clear coincident with a completing beat wins; lane 0 must re-earn its flag
        send_set(0, 1'b0, fld(8'hF7, 8'hF7, 8'h10), 0, 1'b1);
        repeat (TGT) send_set(0, 1'b0, fld(8'hF7, 8'hF7, 8'h10), 0, 1'b0);

        // Randomized traffic, sets interleaved across lanes at set boundaries
        for (int n = 0; n < 90; n++) begin
            lane = int'($urandom_range(0, NL - 1));
            ts2  = (lane == 1) ^ ($urandom_range(0, 7) == 0);
            f    = fld(8'(lane), 8'(lane), ($urandom_range(0, 5) == 0) ? 8'h20 : 8'h10);
            bad  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5)) : 0;
            send_set(lane, ts2, f, bad, 1'b0);
        end

        // Reset in the middle of a set
        drive_beat(32'h10_F7_F7_BC, 4'hF, 1'b0, 8'h01);
        drive_beat(32'h4A_4A_00_02, 4'hF, 1'b0, 8'h01);
        @(negedge clk_i);
        tvalid = 1'b0;
        rst_i  = 1'b1;
        #1;
        check("midreset_tready", 64'(tready), 64'(0));
        check("midreset_flags", 64'({sat1, sat2}), 64'(0));
        model_clear();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_tready", 64'(tready), 64'(1));
        send_set(0, 1'b0, fld(8'hF7, 8'hF7, 8'h10), 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
